reg_poll_monitor: RTL

- Synthesizable register monitor that consumes the testbench run configuration (regMonEnable, regPollDelay).
- Periodically scans a fixed window of NUM_REGS registers over a simple request/acknowledge read bus and keeps a shadow copy of each register.
- Emits a change record whenever a register value differs from its shadow.
- Sits between the config stage and the scoreboard/logger that prints register activity.

---
 rtl/reg_poll_monitor.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/reg_poll_monitor.sv
// reg_poll_monitor: periodic register scanner that keeps a shadow of NUM_REGS registers and reports value changes.
// Latency: first read D=max(poll_delay,1) enabled cycles after WAIT entry, one idle cycle between reads, change record the cycle after rd_ack.
// Backpressure: reads are held until rd_ack or TIMEOUT; a pending change record stalls the scan until chg_ready.
//
// Ports:
//   i_clk, i_rst          clock (rising edge) and asynchronous active-high reset
//   i_enable              monitor enable; WAIT countdown holds while low, a running scan stops at the next register boundary
//   i_poll_delay          idle cycles between scans, 0 treated as 1, sampled only when the countdown is loaded
//   o_rd_req/o_rd_addr    read request and address, held until i_rd_ack or timeout
//   i_rd_ack/i_rd_data    read acknowledge and data (data valid in the ack cycle)
//   o_chg_valid/i_chg_ready, o_chg_index/o_chg_old/o_chg_new   change record handshake and payload
//   o_scan_done           one-cycle pulse after the last register of a complete scan
//   o_timeout_err         sticky read-timeout flag
//   o_busy                high whenever the monitor is not idling between scans
module reg_poll_monitor #(
  parameter int NUM_REGS  = 8,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0,
  parameter int STRIDE    = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [31:0]       i_poll_delay,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_ack,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_chg_valid,
  input  logic              i_chg_ready,
  output logic [7:0]        o_chg_index,
  output logic [DATA_W-1:0] o_chg_old,
  output logic [DATA_W-1:0] o_chg_new,
  output logic              o_scan_done,
  output logic              o_timeout_err,
  output logic              o_busy
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_REQ    = 2'd1,
    S_REPORT = 2'd2,
    S_NEXT   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_first;       // countdown not yet loaded since reset
  logic [31:0]         r_dcnt;
  logic [TO_W-1:0]     r_tcnt;
  logic [7:0]          r_idx;
  logic [NUM_REGS-1:0] r_sh_vld;
  logic [DATA_W-1:0]   r_shadow [NUM_REGS];
  logic [7:0]          r_chg_index;
  logic [DATA_W-1:0]   r_chg_old;
  logic [DATA_W-1:0]   r_chg_new;
  logic                r_tout_err;

  logic [IDX_W-1:0]    w_sidx;
  logic                w_last;
  logic [31:0]         w_dload;
  logic                w_tout;
  logic                w_diff;

  assign w_sidx  = r_idx[IDX_W-1:0];
  assign w_last  = (r_idx == 8'(NUM_REGS - 1));
  assign w_dload = (i_poll_delay == 32'd0) ? 32'd1 : i_poll_delay;
  // An ack arriving in the last allowed cycle wins over the timeout.
  assign w_tout  = !i_rd_ack && (r_tcnt == TO_W'(TIMEOUT - 1));
  // The first read of a register after reset only establishes the baseline.
  assign w_diff  = r_sh_vld[w_sidx] && (i_rd_data != r_shadow[w_sidx]);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT: begin
        if (!r_first && i_enable && (r_dcnt == 32'd1)) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (i_rd_ack) begin
          w_state_nxt = w_diff ? S_REPORT : S_NEXT;
        end else if (w_tout) begin
          w_state_nxt = S_NEXT;
        end
      end
      S_REPORT: begin
        if (i_chg_ready) begin
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        // Dropping enable ends the scan early without a scan_done pulse.
        w_state_nxt = (w_last || !i_enable) ? S_WAIT : S_REQ;
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Counters, index, shadow-valid bits and change record
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_first     <= 1'b1;
      r_dcnt      <= 32'd0;
      r_tcnt      <= '0;
      r_idx       <= 8'd0;
      r_sh_vld    <= '0;
      r_chg_index <= 8'd0;
      r_chg_old   <= '0;
      r_chg_new   <= '0;
      r_tout_err  <= 1'b0;
    end else begin
      r_first <= 1'b0;
      r_tcnt  <= (r_state == S_REQ) ? (r_tcnt + TO_W'(1)) : '0;
      case (r_state)
        S_WAIT: begin
          if (r_first) begin
            r_dcnt <= w_dload;
          end else if (i_enable && (r_dcnt != 32'd1)) begin
            r_dcnt <= r_dcnt - 32'd1;
          end
        end
        S_REQ: begin
          if (i_rd_ack) begin
            r_sh_vld[w_sidx] <= 1'b1;
            if (w_diff) begin
              r_chg_index <= r_idx;
              r_chg_old   <= r_shadow[w_sidx];
              r_chg_new   <= i_rd_data;
            end
          end else if (w_tout) begin
            r_tout_err <= 1'b1;
          end
        end
        S_NEXT: begin
          if (w_state_nxt == S_WAIT) begin
            r_idx  <= 8'd0;
            r_dcnt <= w_dload;
          end else begin
            r_idx <= r_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow storage needs no reset: entries are qualified by r_sh_vld.
  always_ff @(posedge i_clk) begin
    if ((r_state == S_REQ) && i_rd_ack) begin
      r_shadow[w_sidx] <= i_rd_data;
    end
  end

  // Outputs
  always_comb begin
    o_rd_req      = (r_state == S_REQ);
    o_chg_valid   = (r_state == S_REPORT);
    o_scan_done   = (r_state == S_NEXT) && w_last;
    o_busy        = (r_state != S_WAIT);
    o_rd_addr     = ADDR_W'(BASE_ADDR + 32'(r_idx) * STRIDE);
    o_chg_index   = r_chg_index;
    o_chg_old     = r_chg_old;
    o_chg_new     = r_chg_new;
    o_timeout_err = r_tout_err;
  end

endmodule
